// File: rtl/uart_defines.sv
// Shared constants for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions and FSM state encodings.
package uart_defines;

  // Word offsets within the 16-byte register window (addr[3:2])
  localparam logic [1:0] UART_TXDATA  = 2'd0;
  localparam logic [1:0] UART_STATUS  = 2'd1;
  localparam logic [1:0] UART_BAUDDIV = 2'd2;

  // STATUS register bit positions
  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

  // Transmit FSM states
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational read port.
// Full/empty derive from an occupancy counter one bit wider than the pointers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_q];

  // Next pointers and occupancy; simultaneous push+pop leaves count unchanged
  always_comb begin
    wr_d  = wr_q + PW'(do_push);
    rd_d  = rd_q + PW'(do_pop);
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: contents are only visible when count says so
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter sitting on the core's data port.
// Stores to TXDATA queue bytes; a bit-timing FSM shifts them out on tx.
module uart_tx_mmio
  import uart_defines::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        tx_idle
);
  logic        sel, wr_sel, wr_tx, push, pop, full, empty;
  logic [1:0]  off;
  logic [7:0]  fifo_dout;
  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d, baud_q, baud_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic        tx_q, tx_d, ovf_q, ovf_d;
  logic        unused_bits;

  assign sel         = (addr[31:4] == BASE_ADDR[31:4]);
  assign off         = addr[3:2];
  assign wr_sel      = we & sel;
  assign wr_tx       = wr_sel & (off == UART_TXDATA);
  // Full is sampled before any same-edge pop, so a write while full is lost
  assign push        = wr_tx & ~full;
  assign unused_bits = ^{addr[1:0], write_data[31:16]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (write_data[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  // Register writes: sticky overflow and baud divisor (0 coerced to 1)
  always_comb begin
    ovf_d  = ovf_q;
    baud_d = baud_q;
    if (wr_tx && full) ovf_d = 1'b1;
    if (wr_sel && off == UART_STATUS && write_data[ST_OVF]) ovf_d = 1'b0;
    if (wr_sel && off == UART_BAUDDIV)
      baud_d = (write_data[15:0] == 16'd0) ? 16'd1 : write_data[15:0];
  end

  // Bit-timing FSM: each bit held for baud_q clocks, counter reloaded per bit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = fifo_dout;
          cnt_d   = baud_q - 16'd1;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        else begin
          cnt_d   = baud_q - 16'd1;
          idx_d   = 3'd0;
          tx_d    = sh_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        else begin
          cnt_d = baud_q - 16'd1;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
          end
        end
      end
      S_STOP: begin
        if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        else state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; tx resets high so the line idles immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      baud_q  <= DEFAULT_DIV;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      baud_q  <= baud_d;
    end
  end

  // Combinational read mux; zero when the window is not addressed
  always_comb begin
    read_data = 32'd0;
    if (sel) begin
      case (off)
        UART_STATUS:  read_data = {28'd0, ovf_q, empty, full, state_q != S_IDLE};
        UART_BAUDDIV: read_data = {16'd0, baud_q};
        default:      read_data = 32'd0;
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_idle = empty & (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomised bench for uart_tx_mmio. A timeline model schedules each
// accepted byte's frame (pop edge, divisor) and predicts tx, tx_idle and
// STATUS at every clock.
module tb_uart_tx_mmio;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst_n = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, write_data = '0, read_data;
  logic        tx, tx_idle;

  uart_tx_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd16)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .write_data(write_data),
    .read_data(read_data), .tx(tx), .tx_idle(tx_idle)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;

  // Model: one entry per accepted byte
  int         m_push[$], m_pop[$], m_b[$];
  logic [7:0] m_byte[$];
  int         m_baud = 16;
  logic       m_ovf  = 1'b0;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic void model_clear();
    m_push.delete(); m_pop.delete(); m_b.delete(); m_byte.delete();
    m_baud = 16; m_ovf = 1'b0;
  endfunction

  // Line level after edge k: start bit 0, data LSB first, stop bit 1
  function automatic logic exp_tx(int k);
    for (int i = 0; i < m_pop.size(); i++) begin
      if (k >= m_pop[i] && k < m_pop[i] + 10*m_b[i]) begin
        int j;
        j = (k - m_pop[i]) / m_b[i];
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return m_byte[i][j-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic int fifo_cnt(int k);
    int n = 0;
    for (int i = 0; i < m_pop.size(); i++)
      if (m_push[i] <= k && m_pop[i] > k) n++;
    return n;
  endfunction

  function automatic logic frame_busy(int k);
    for (int i = 0; i < m_pop.size(); i++)
      if (k >= m_pop[i] && k < m_pop[i] + 10*m_b[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_idle(int k);
    return (fifo_cnt(k) == 0) && !frame_busy(k);
  endfunction

  function automatic logic [31:0] exp_status(int k);
    int n;
    n = fifo_cnt(k);
    return {28'd0, m_ovf, n == 0, n == DEPTH, frame_busy(k)};
  endfunction

  // Apply a bus write occurring at edge e to the model
  function automatic void model_write(int e, logic [31:0] a, logic [31:0] d);
    int occ, p, n;
    if (a[31:4] != BASE[31:4]) return;
    case (a[3:2])
      2'd0: begin
        occ = 0;
        for (int i = 0; i < m_pop.size(); i++)
          if (m_push[i] < e && m_pop[i] >= e) occ++;
        if (occ >= DEPTH) m_ovf = 1'b1;
        else begin
          p = e + 1;
          n = m_pop.size();
          if (n > 0 && m_pop[n-1] + 10*m_b[n-1] + 1 > p) p = m_pop[n-1] + 10*m_b[n-1] + 1;
          m_push.push_back(e); m_pop.push_back(p); m_b.push_back(m_baud);
          m_byte.push_back(d[7:0]);
        end
      end
      2'd1: if (d[3]) m_ovf = 1'b0;
      2'd2: m_baud = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
      default: ;
    endcase
  endfunction

  // Per-clock line and idle check, sampled away from the edge
  always @(posedge clk) begin
    cyc++;
    #2;
    chk("tx", {31'd0, tx}, {31'd0, exp_tx(cyc)});
    chk("tx_idle", {31'd0, tx_idle}, {31'd0, exp_idle(cyc)});
  end

  task automatic wr(logic [31:0] a, logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; write_data = d;
    model_write(cyc + 1, a, d);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    we = 1'b0; addr = '0; write_data = '0;
  endtask

  task automatic rd(logic [31:0] a, logic [31:0] exp, string tag);
    @(negedge clk);
    we = 1'b0; addr = a;
    #1 chk(tag, read_data, exp);
  endtask

  task automatic rd_status(string tag);
    @(negedge clk);
    we = 1'b0; addr = BASE + 32'h4;
    #1 chk(tag, read_data, exp_status(cyc));
  endtask

  task automatic wait_idle(int bound);
    int n = 0;
    idle_bus();
    while (!exp_idle(cyc) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p, b, n, sel;
    logic [31:0] a;

    // Reset state and decode
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    rd(BASE + 32'h4, 32'h4, "rst_status");
    rd(BASE + 32'h8, 32'h10, "rst_baud");
    rd(BASE + 32'hC, 32'h0, "rsvd_read");
    rd(BASE + 32'h0, 32'h0, "txdata_read");
    rd(32'h2000_0004, 32'h0, "outside_read");
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_tx_idle", {31'd0, tx_idle}, 32'd1);

    // Single byte at divisor 4
    wr(BASE + 32'h8, 32'd4);
    wr(BASE, 32'hA5);
    wait_idle(100);
    chk("a5_frame_len", 32'(m_b[0] * 10), 32'd40);

    // Back-to-back writes overflow the FIFO
    wr(BASE + 32'h8, 32'd2);
    for (int i = 1; i <= 6; i++) wr(BASE, 32'(i));
    rd_status("st_full_ovf");
    chk("st_full_ovf_val", read_data, 32'hB);
    wait_idle(200);
    rd_status("st_ovf_held");
    wr(BASE + 32'h4, 32'h8);
    rd_status("st_ovf_clr");
    chk("st_ovf_clr_val", read_data, 32'h4);

    // Divisor 0 coerces to 1
    wr(BASE + 32'h8, 32'd0);
    rd(BASE + 32'h8, 32'h1, "baud_zero");
    wr(BASE, 32'hFF);
    wait_idle(40);

    // Randomised traffic against the timeline model
    for (int r = 0; r < 12; r++) begin
      b = $urandom_range(1, 5);
      wr(BASE + 32'h8, 32'(b));
      rd(BASE + 32'h8, 32'(b), "rand_baud");
      n = $urandom_range(2, 8);
      for (int k = 0; k < n; k++) begin
        sel = $urandom_range(0, 11);
        if (sel < 7) wr(BASE, $urandom);
        else if (sel == 7) rd_status("rand_status");
        else if (sel == 8) begin
          a = $urandom;
          if (a[31:4] == BASE[31:4]) a[31] = ~a[31];
          wr(a, $urandom);
        end else if (sel == 9) wr(BASE + 32'hC, $urandom);
        else if (sel == 10) wr(BASE + 32'h4, $urandom);
        else repeat ($urandom_range(1, 3*b)) idle_bus();
      end
      rd_status("rand_status_end");
      wait_idle(400);
    end

    // Reset during DATA bit 3 of 0x35 (bit 3 = 0), with a second byte queued
    wr(BASE + 32'h8, 32'd4);
    wr(BASE, 32'h35);
    wr(BASE, 32'h81);
    idle_bus();
    p = m_pop[m_pop.size() - 2];
    while (cyc < p + 17) @(negedge clk);
    chk("pre_rst_tx", {31'd0, tx}, 32'd0);
    rst_n = 1'b0;
    model_clear();
    #1 chk("rst_async_tx", {31'd0, tx}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_status("post_rst_status");
    rd(BASE + 32'h8, 32'h10, "post_rst_baud");
    repeat (60) idle_bus();

    // Writes outside the window change nothing
    wr(BASE + 32'h10, 32'h55);
    wr(BASE + 32'h18, 32'h3);
    rd_status("nosel_status");
    rd(BASE + 32'h8, 32'h10, "nosel_baud");
    repeat (20) idle_bus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
